xunit_f_round: RTL and testbench
================================

# xunit_f_round

SHA-256 compression stage for the Versat datapath, directly downstream of the message-schedule unit. It consumes one schedule word W[t] and one round constant K[t] per cycle for 64 cycles and runs the SHA-256 round function on working variables a..h. It then adds the result into its resident hash state H0..H7 (feed-forward) and presents H0..H7 as outputs for the memory/output units.

## Interface
- DATA_W, 32, word width; only 32 is supported.
- DELAY_W, 8, width of configDelay and the alignment counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start pulse; has priority over all other activity.
- done  out  1  high when idle (state IDLE).
- in0  in  DATA_W  W[t] from the schedule unit.
- in1  in  DATA_W  K[t] from the constant memory.
- out0..out7  out  DATA_W  each  hash state H0..H7.
- configDelay  in  DELAY_W  cycles to wait after run before round 0 data is valid.

## Operation
- FSM states: IDLE, WAIT, ROUND, FINAL.
- Reset (rst_n low, asynchronous):
  - state = IDLE; delay and round counters = 0; a..h = 0.
  - H0..H7 = SHA-256 IV (0x6a09e667, 0xbb67ae85, 0x3c6ef372, 0xa54ff53a, 0x510e527f, 0x9b05688c, 0x1f83d9ab, 0x5be0cd19).
  - Result: out0..out7 = IV and done = 1.
- run sampled high, in any state:
  - a..h <= H0..H7; round counter <= 0.
  - If configDelay == 0: state <= ROUND. Otherwise: delay counter <= configDelay, state <= WAIT.
  - A run during WAIT, ROUND or FINAL abandons the current block. a..h are reloaded from the unchanged H.
- WAIT: delay counter decrements each cycle. When it reaches 1, state <= ROUND on the same edge.
- ROUND, round t = round counter (6 bits):
  - T1 = h + Σ1(e) + Ch(e,f,g) + in1 + in0
  - T2 = Σ0(a) + Maj(a,b,c)
  - All additions are mod 2^32 with carries discarded.
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - At t == 63, state <= FINAL; otherwise the counter increments.
- FINAL: Hi <= Hi + {a..h}[i] mod 2^32, then state <= IDLE. H persists across blocks, so consecutive runs chain multi-block messages.
- in0 and in1 are ignored outside ROUND.

## Timing
- Run edge = edge 0, with D = configDelay.
- W[t]/K[t] are sampled at edge D+1+t, for t = 0..63.
- H is updated at edge D+65. done rises after edge D+65, so block latency is D+65 cycles.
- done falls in the cycle after the run edge. It is a combinational decode of state; no extra register.
- out0..out7 are registered H. They change only at the FINAL edge, reset, or an IV reload.

## Configuration
- Macro: XUNIT_F_ROUND_IV_RELOAD_EN.
- Defined:
  - Adds input configInit (1 bit).
  - run with configInit = 1 loads H0..H7 <= IV and a..h <= IV on the run edge, which starts a new message without reset.
  - run with configInit = 0 behaves as the undefined case.
- Undefined: no configInit port. H is reloaded to IV only by rst_n.

## Structure
- Shared package sha256_pkg:
  - IV constants.
  - State enum.
  - Functions Σ0, Σ1, Ch, Maj (ROTR 2/13/22 and 6/11/25).
- Sub-module sha256_round: purely combinational.
  - Inputs: a..h, W, K. Outputs: next a..h.
  - Instantiated once; the FSM/counters and H registers stay in the top.

## Test plan
- Reset: hold rst_n low mid-ROUND.
  - Immediately: done = 1, out0 = 0x6a09e667, out7 = 0x5be0cd19.
  - After release: stays idle until run.
- "abc" single block, D = 0: drive the 64 correct W[t] and K[t].
  - At edge 65: out0 = 0xba7816bf, out7 = 0xf20015ad.
  - done low exactly for 65 cycles.
- Same vector with D = 5: output sampled at edge 70 matches; inputs driven during WAIT are ignored.
- Two-block message (56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), back-to-back runs:
  - out0 = 0x248d6a61, out7 = 0x19db06c1.
- Run re-asserted at round 30: restarts with H unchanged; the next complete block yields the single-block result.
- With XUNIT_F_ROUND_IV_RELOAD_EN: after the "abc" hash, run with configInit = 1 and "abc" again gives out0 = 0xba7816bf. With configInit = 0, the result differs from that.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_pkg : SHA-256 IV, FSM state encoding and round helper functions
// Revision   : 1.0
// ----------------------------------------------------------------------------
package sha256_pkg;

  localparam int CFG_DELAY_W = 8;

  typedef logic [31:0]      word_t;
  // Working variables / hash words; index 0 is a (H0), index 7 is h (H7).
  typedef logic [7:0][31:0] vars_t;

  localparam vars_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ROUND = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xunit_f_round_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xunit_f_round_if : control/data bundle of the SHA-256 compression stage
// Revision         : 1.0  (configInit exists with XUNIT_F_ROUND_IV_RELOAD_EN)
// ----------------------------------------------------------------------------
interface xunit_f_round_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
);
  logic               run;
  logic               done;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  in1;
  logic [DELAY_W-1:0] configDelay;
`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
  logic               configInit;
`endif
  logic [DATA_W-1:0]  out0, out1, out2, out3, out4, out5, out6, out7;

  modport master (
    output run, in0, in1, configDelay,
`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
    output configInit,
`endif
    input  done, out0, out1, out2, out3, out4, out5, out6, out7
  );

  modport slave (
    input  run, in0, in1, configDelay,
`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
    input  configInit,
`endif
    output done, out0, out1, out2, out3, out4, out5, out6, out7
  );
endinterface
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_round : one combinational SHA-256 round over working variables a..h
// Revision     : 1.0
// ----------------------------------------------------------------------------
module sha256_round
  import sha256_pkg::*;
(
  input  vars_t i_vars,
  input  word_t i_w,
  input  word_t i_k,
  output vars_t o_vars
);
  word_t w_t1;
  word_t w_t2;

  always_comb begin
    w_t1      = i_vars[7] + big_sigma1(i_vars[4]) + ch(i_vars[4], i_vars[5], i_vars[6])
              + i_k + i_w;
    w_t2      = big_sigma0(i_vars[0]) + maj(i_vars[0], i_vars[1], i_vars[2]);
    o_vars[0] = w_t1 + w_t2;
    o_vars[1] = i_vars[0];
    o_vars[2] = i_vars[1];
    o_vars[3] = i_vars[2];
    o_vars[4] = i_vars[3] + w_t1;
    o_vars[5] = i_vars[4];
    o_vars[6] = i_vars[5];
    o_vars[7] = i_vars[6];
  end
endmodule
`default_nettype wire

// File: rtl/xunit_f_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xunit_f_round : SHA-256 compression stage (64 rounds + feed-forward into H)
// Revision      : 1.0  (XUNIT_F_ROUND_IV_RELOAD_EN adds run-time IV reload)
// ----------------------------------------------------------------------------
module xunit_f_round
  import sha256_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      rst_n,
  xunit_f_round_if.slave bus
);
  localparam logic [CFG_DELAY_W-1:0] c_DELAY_ONE = 1;

  state_t                 r_state, w_state_nxt;
  logic [CFG_DELAY_W-1:0] r_delay, w_delay_nxt;
  logic [5:0]             r_round, w_round_nxt;
  vars_t                  r_work, w_work_nxt;
  vars_t                  r_hash, w_hash_nxt;
  vars_t                  w_round_vars;
  vars_t                  w_seed;
  logic                   w_init;

`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
  assign w_init = bus.configInit;
`else
  assign w_init = 1'b0;
`endif

  // A new block starts either from the resident H (chaining) or from the IV.
  assign w_seed = w_init ? IV : r_hash;

  sha256_round u_round (
    .i_vars (r_work),
    .i_w    (bus.in0),
    .i_k    (bus.in1),
    .o_vars (w_round_vars)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_delay <= '0;
      r_round <= '0;
      r_work  <= '0;
      r_hash  <= IV;
    end else begin
      r_state <= w_state_nxt;
      r_delay <= w_delay_nxt;
      r_round <= w_round_nxt;
      r_work  <= w_work_nxt;
      r_hash  <= w_hash_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_round_nxt = r_round;
    w_work_nxt  = r_work;
    w_hash_nxt  = r_hash;
    if (bus.run) begin
      w_work_nxt  = w_seed;
      w_hash_nxt  = w_seed;
      w_round_nxt = '0;
      if (bus.configDelay == '0) begin
        w_state_nxt = S_ROUND;
      end else begin
        w_delay_nxt = bus.configDelay;
        w_state_nxt = S_WAIT;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          w_delay_nxt = r_delay - c_DELAY_ONE;
          if (r_delay == c_DELAY_ONE) w_state_nxt = S_ROUND;
        end
        S_ROUND: begin
          w_work_nxt = w_round_vars;
          if (r_round == 6'd63) w_state_nxt = S_FINAL;
          else                  w_round_nxt = r_round + 6'd1;
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) w_hash_nxt[i] = r_hash[i] + r_work[i];
          w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign bus.done = (r_state == S_IDLE);
  assign bus.out0 = r_hash[0];
  assign bus.out1 = r_hash[1];
  assign bus.out2 = r_hash[2];
  assign bus.out3 = r_hash[3];
  assign bus.out4 = r_hash[4];
  assign bus.out5 = r_hash[5];
  assign bus.out6 = r_hash[6];
  assign bus.out7 = r_hash[7];
endmodule
`default_nettype wire

// File: tb/tb_xunit_f_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xunit_f_round : directed bench for the SHA-256 compression stage
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_xunit_f_round;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lowcnt = 0;
  logic cfg_init = 1'b0;

  logic [31:0] ws    [64];
  logic [31:0] k_tab [64];
  logic [31:0] iv_tab [8];
  logic [31:0] outs  [8];

  always #5 clk = ~clk;

  xunit_f_round_if bus ();

  xunit_f_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  // Message schedule of a padded block: 0 = "abc", 1/2 = two-block message.
  task automatic load_sched(input int sel);
    for (int i = 0; i < 16; i++) ws[i] = 32'h0;
    case (sel)
      0: begin
        ws[0]  = 32'h61626380;
        ws[15] = 32'h00000018;
      end
      1: begin
        for (int i = 0; i < 14; i++) ws[i] = 32'h61626364 + i * 32'h01010101;
        ws[14] = 32'h80000000;
      end
      default: ws[15] = 32'h000001c0;
    endcase
    for (int t = 16; t < 64; t++)
      ws[t] = ssig1(ws[t-2]) + ws[t-7] + ssig0(ws[t-15]) + ws[t-16];
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.done === 1'b0) lowcnt++;
  endtask

  task automatic grab_outs();
    outs = '{bus.out0, bus.out1, bus.out2, bus.out3,
             bus.out4, bus.out5, bus.out6, bus.out7};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the DUT sampled in FINAL; the caller performs the last step.
  task automatic drive_block(input int sel, input int d, input int abort_at);
    int t;
    int ab;
    load_sched(sel);
    ab = abort_at;
    bus.run = 1'b1;
    bus.configDelay = 8'(d);
`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
    bus.configInit = cfg_init;
`endif
    bus.in0 = $urandom;
    bus.in1 = $urandom;
    lowcnt = 0;
    step();
    bus.run = 1'b0;
`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
    bus.configInit = 1'b0;
`endif
    for (int e = 0; e < d; e++) begin
      bus.in0 = $urandom;
      bus.in1 = $urandom;
      step();
    end
    t = 0;
    while (t < 64) begin
      if (t == ab) begin
        bus.run = 1'b1;
        bus.configDelay = 8'd0;
        step();
        bus.run = 1'b0;
        lowcnt = 1;
        ab = -1;
        t = 0;
      end else begin
        bus.in0 = ws[t];
        bus.in1 = k_tab[t];
        step();
        t++;
      end
    end
    bus.in0 = $urandom;
    bus.in1 = $urandom;
  endtask

  task automatic test_reset();
    do_reset();
    grab_outs();
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL por_done: got %b want 1", bus.done); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== iv_tab[i]) begin
        errors++; $display("FAIL por_out%0d: got %h want %h", i, outs[i], iv_tab[i]);
      end
    end
    // Start a block and pull reset asynchronously in the middle of ROUND.
    load_sched(0);
    bus.run = 1'b1;
    bus.configDelay = 8'd0;
    step();
    bus.run = 1'b0;
    for (int t = 0; t < 10; t++) begin
      bus.in0 = ws[t];
      bus.in1 = k_tab[t];
      step();
    end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.done); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL rst_done: got %b want 1", bus.done); end
    checks++;
    if (bus.out0 !== 32'h6a09e667) begin errors++; $display("FAIL rst_out0: got %h want 6a09e667", bus.out0); end
    checks++;
    if (bus.out7 !== 32'h5be0cd19) begin errors++; $display("FAIL rst_out7: got %h want 5be0cd19", bus.out7); end
    @(negedge clk);
    rst_n = 1'b1;
    lowcnt = 0;
    repeat (4) begin
      bus.in0 = $urandom;
      bus.in1 = $urandom;
      step();
    end
    checks++;
    if (lowcnt !== 0) begin errors++; $display("FAIL post_rst_idle: got %0d busy cycles want 0", lowcnt); end
    checks++;
    if (bus.out0 !== 32'h6a09e667) begin errors++; $display("FAIL post_rst_out0: got %h want 6a09e667", bus.out0); end
  endtask

  task automatic test_abc_d0();
    drive_block(0, 0, -1);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL d0_final_busy: got %b want 0", bus.done); end
    checks++;
    if (bus.out0 !== 32'h6a09e667) begin errors++; $display("FAIL d0_out_hold: got %h want 6a09e667", bus.out0); end
    step();
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL d0_done: got %b want 1", bus.done); end
    checks++;
    if (lowcnt !== 65) begin errors++; $display("FAIL d0_latency: got %0d want 65", lowcnt); end
    checks++;
    if (bus.out0 !== 32'hba7816bf) begin errors++; $display("FAIL d0_out0: got %h want ba7816bf", bus.out0); end
    checks++;
    if (bus.out7 !== 32'hf20015ad) begin errors++; $display("FAIL d0_out7: got %h want f20015ad", bus.out7); end
  endtask

  task automatic test_abc_d5();
    do_reset();
    drive_block(0, 5, -1);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL d5_final_busy: got %b want 0", bus.done); end
    step();
    checks++;
    if (lowcnt !== 70) begin errors++; $display("FAIL d5_latency: got %0d want 70", lowcnt); end
    checks++;
    if (bus.out0 !== 32'hba7816bf) begin errors++; $display("FAIL d5_out0: got %h want ba7816bf", bus.out0); end
    checks++;
    if (bus.out7 !== 32'hf20015ad) begin errors++; $display("FAIL d5_out7: got %h want f20015ad", bus.out7); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_block(1, 0, -1);
    step();
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_mid_done: got %b want 1", bus.done); end
    drive_block(2, 0, -1);
    step();
    checks++;
    if (bus.out0 !== 32'h248d6a61) begin errors++; $display("FAIL b2b_out0: got %h want 248d6a61", bus.out0); end
    checks++;
    if (bus.out7 !== 32'h19db06c1) begin errors++; $display("FAIL b2b_out7: got %h want 19db06c1", bus.out7); end
  endtask

  task automatic test_restart();
    do_reset();
    drive_block(0, 0, 30);
    step();
    checks++;
    if (lowcnt !== 65) begin errors++; $display("FAIL rs_latency: got %0d want 65", lowcnt); end
    checks++;
    if (bus.out0 !== 32'hba7816bf) begin errors++; $display("FAIL rs_out0: got %h want ba7816bf", bus.out0); end
    checks++;
    if (bus.out7 !== 32'hf20015ad) begin errors++; $display("FAIL rs_out7: got %h want f20015ad", bus.out7); end
  endtask

`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
  task automatic test_iv_reload();
    // H holds the "abc" digest here, so only an IV reload reproduces it.
    cfg_init = 1'b1;
    drive_block(0, 0, -1);
    step();
    checks++;
    if (bus.out0 !== 32'hba7816bf) begin errors++; $display("FAIL ivr_init1_out0: got %h want ba7816bf", bus.out0); end
    cfg_init = 1'b0;
    drive_block(0, 0, -1);
    step();
    checks++;
    if (bus.out0 === 32'hba7816bf) begin errors++; $display("FAIL ivr_init0_out0: got %h want value other than ba7816bf", bus.out0); end
  endtask
`endif

  initial begin
    k_tab = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    iv_tab = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    bus.run = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    bus.configDelay = '0;
`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
    bus.configInit = 1'b0;
`endif
    test_reset();
    test_abc_d0();
    test_abc_d5();
    test_back_to_back();
    test_restart();
`ifdef XUNIT_F_ROUND_IV_RELOAD_EN
    test_iv_reload();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
